// File: rtl/tea_pkg.sv
// Shared definitions for the TEA cipher core: key-schedule constant,
// FSM state encoding, mode encoding and the initial decrypt sum helper.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF0 = 2'd1,
    HALF1 = 2'd2,
    DONE  = 2'd3
  } tea_state_e;

  // Decryption starts from the sum encryption ends on: delta * rounds, mod 2^32.
  function automatic logic [31:0] tea_dec_sum(input logic [31:0] delta,
                                              input logic [7:0]  rounds);
    logic [39:0] prod;
    prod = {8'd0, delta} * {32'd0, rounds};
    return prod[31:0];
  endfunction

endpackage

// File: rtl/tea_mix.sv
// TEA round function F(x, ka, kb, s) = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb).
// Purely combinational; all arithmetic wraps mod 2^32 and shifts are logical.
module tea_mix (
  input  logic [31:0] x_i,
  input  logic [31:0] ka_i,
  input  logic [31:0] kb_i,
  input  logic [31:0] s_i,
  output logic [31:0] f_o
);

  logic [31:0] term_a_s;
  logic [31:0] term_b_s;
  logic [31:0] term_c_s;

  assign term_a_s = (x_i << 4) + ka_i;
  assign term_b_s = x_i + s_i;
  assign term_c_s = (x_i >> 5) + kb_i;
  assign f_o      = term_a_s ^ term_b_s ^ term_c_s;

endmodule

// File: rtl/tea_cipher_core.sv
// TEA block-cipher engine: one 64-bit block per transaction, encrypt or
// decrypt selected per block, ROUNDS Feistel cycles of two half-rounds each.
// Key and mode are captured at accept so the block in flight is immune to
// input changes. A single shared round-function instance is steered by
// state and mode.
module tea_cipher_core
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [31:0]  in_v0,
  input  logic [31:0]  in_v1,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         busy
);

  localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [31:0] DEC_SUM0   = tea_dec_sum(DELTA, 8'(ROUNDS));

  tea_state_e   state_q;
  logic [31:0]  v0_q, v1_q, sum_q;
  logic [31:0]  v0_d, v1_d, sum_d;
  logic [7:0]   cnt_q;
  logic [127:0] key_q;
  logic         mode_q;
  logic [31:0]  out_v0_q, out_v1_q;
  logic         out_valid_q, busy_q, in_ready_q;

  logic         use_k01_s;
  logic [31:0]  mix_x_s, mix_ka_s, mix_kb_s, mix_f_s;

  // Steer the shared round function: the k0/k1 half mixes v1, the k2/k3 half mixes v0.
  always_comb begin
    use_k01_s = ((state_q == HALF0) == (mode_q == MODE_ENC));
    if (use_k01_s) begin
      mix_x_s  = v1_q;
      mix_ka_s = key_q[127:96];
      mix_kb_s = key_q[95:64];
    end else begin
      mix_x_s  = v0_q;
      mix_ka_s = key_q[63:32];
      mix_kb_s = key_q[31:0];
    end
  end

  tea_mix u_mix (
    .x_i  (mix_x_s),
    .ka_i (mix_ka_s),
    .kb_i (mix_kb_s),
    .s_i  (sum_q),
    .f_o  (mix_f_s)
  );

  // Half-round datapath: next block words and running sum for the current state.
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    sum_d = sum_q;
    case (state_q)
      HALF0: begin
        if (mode_q == MODE_ENC) begin
          v0_d = v0_q + mix_f_s;
        end else begin
          v1_d = v1_q - mix_f_s;
        end
      end
      HALF1: begin
        if (mode_q == MODE_ENC) begin
          v1_d  = v1_q + mix_f_s;
          sum_d = sum_q + DELTA;
        end else begin
          v0_d  = v0_q - mix_f_s;
          sum_d = sum_q - DELTA;
        end
      end
      default: begin
        v0_d  = v0_q;
        v1_d  = v1_q;
        sum_d = sum_q;
      end
    endcase
  end

  // Sequencer, register file and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      v0_q        <= 32'd0;
      v1_q        <= 32'd0;
      sum_q       <= 32'd0;
      cnt_q       <= 8'd0;
      key_q       <= 128'd0;
      mode_q      <= MODE_ENC;
      out_v0_q    <= 32'd0;
      out_v1_q    <= 32'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            v0_q       <= in_v0;
            v1_q       <= in_v1;
            key_q      <= in_key;
            mode_q     <= in_mode;
            sum_q      <= (in_mode == MODE_ENC) ? DELTA : DEC_SUM0;
            cnt_q      <= 8'd0;
            state_q    <= HALF0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        HALF0: begin
          v0_q    <= v0_d;
          v1_q    <= v1_d;
          state_q <= HALF1;
        end
        HALF1: begin
          v0_q  <= v0_d;
          v1_q  <= v1_d;
          sum_q <= sum_d;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == LAST_ROUND) begin
            state_q     <= DONE;
            out_v0_q    <= v0_d;
            out_v1_q    <= v1_d;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= HALF0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_v0    = out_v0_q;
  assign out_v1    = out_v1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tea_cipher_core.sv
// Self-checking bench for tea_cipher_core: known vectors, random
// encrypt/decrypt round trips against a plain TEA model, backpressure,
// mid-block input changes, mid-block reset, and a ROUNDS=1 instance.
module tb_tea_cipher_core;

  localparam logic [31:0] D = 32'h9E3779B9;
  localparam int R = 32;

  logic         clk;
  logic         resetn;
  logic         in_valid, in_ready, in_mode;
  logic [31:0]  in_v0, in_v1;
  logic [127:0] in_key;
  logic         out_valid, out_ready, busy;
  logic [31:0]  out_v0, out_v1;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0]  out_v0_1, out_v1_1;

  int n_tests = 0;
  int n_fail  = 0;

  tea_cipher_core dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .busy(busy)
  );

  tea_cipher_core #(.ROUNDS(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode),
    .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_v0(out_v0_1), .out_v1(out_v1_1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Textbook TEA, written as the classic C loop.
  function automatic logic [63:0] tea_model(input bit dec, input logic [31:0] a_in,
                                            input logic [31:0] b_in, input logic [127:0] k,
                                            input int rounds);
    logic [31:0] a, b, s, k0, k1, k2, k3;
    a = a_in; b = b_in;
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    s = 32'd0;
    if (!dec) begin
      for (int r = 0; r < rounds; r++) begin
        s = s + D;
        a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
        b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
      end
    end else begin
      for (int r = 0; r < rounds; r++) s = s + D;
      for (int r = 0; r < rounds; r++) begin
        b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
        a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
        s = s - D;
      end
    end
    return {a, b};
  endfunction

  task automatic start_block(input bit mode, input logic [31:0] a, input logic [31:0] b,
                             input logic [127:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 300) begin
      step();
      guard++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_mode = mode; in_v0 = a; in_v1 = b; in_key = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 1000) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0]  res, exp, p, c, held;
    logic [127:0] k;
    logic [31:0]  a, b;
    bit           m;
    int           lat;
    bit           seen;

    resetn = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_mode = 1'b0;
    in_v0 = 32'd0; in_v1 = 32'd0; in_key = 128'd0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {out_v0, out_v1}, 64'd0);
    chk("rst_flags", {60'd0, out_valid, busy, in_ready, in_ready1}, {60'd0, 4'b0011});
    resetn = 1'b1;
    step();
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Known vector, encrypt zeros.
    start_block(1'b0, 32'd0, 32'd0, 128'd0);
    wait_done(lat);
    chk("enc_zero_lat", 64'(lat), 64'(2 * R));
    chk("enc_zero", {out_v0, out_v1}, 64'h41EA3A0A_94BAA940);
    handshake();
    chk("out_valid_drop", {62'd0, out_valid, busy}, 64'd0);

    // Known vector, decrypt back.
    start_block(1'b1, 32'h41EA3A0A, 32'h94BAA940, 128'd0);
    wait_done(lat);
    chk("dec_zero_lat", 64'(lat), 64'(2 * R));
    chk("dec_zero", {out_v0, out_v1}, 64'd0);
    handshake();

    // ROUNDS=1 instance.
    in_mode = 1'b0; in_v0 = 32'd0; in_v1 = 32'd0; in_key = 128'd0;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("r1_busy", {63'd0, busy1}, 64'd1);
    lat = 0;
    while (!out_valid1 && lat < 100) begin
      step();
      lat++;
    end
    chk("r1_lat", 64'(lat), 64'd2);
    chk("r1_enc", {out_v0_1, out_v1_1}, 64'h9E3779B9_DBE8D32F);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;

    // Random round trips.
    for (int i = 0; i < 200; i++) begin
      a = $urandom(); b = $urandom();
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {a, b};
      start_block(1'b0, a, b, k);
      wait_done(lat);
      c = {out_v0, out_v1};
      chk("rand_enc", c, tea_model(1'b0, a, b, k, R));
      chk("rand_enc_lat", 64'(lat), 64'(2 * R));
      handshake();
      start_block(1'b1, c[63:32], c[31:0], k);
      wait_done(lat);
      chk("rand_roundtrip", {out_v0, out_v1}, p);
      handshake();
    end

    // Backpressure with a pending request.
    a = $urandom(); b = $urandom(); k = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(1'b0, a, b, k);
    wait_done(lat);
    held = {out_v0, out_v1};
    chk("bp_result", held, tea_model(1'b0, a, b, k, R));
    a = $urandom(); b = $urandom();
    in_mode = 1'b1; in_v0 = a; in_v1 = b;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {out_v0, out_v1}, held);
      chk("bp_flags", {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b101});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b010});
    chk("bp_retain", {out_v0, out_v1}, held);
    step();
    in_valid = 1'b0;
    chk("bp_accept", {62'd0, in_ready, busy}, {62'd0, 2'b01});
    wait_done(lat);
    chk("bp_next_lat", 64'(lat), 64'(2 * R));
    chk("bp_next", {out_v0, out_v1}, tea_model(1'b1, a, b, k, R));
    handshake();

    // Inputs change while a block is in flight.
    for (int i = 0; i < 4; i++) begin
      a = $urandom(); b = $urandom(); m = 1'($urandom_range(0, 1));
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_block(m, a, b, k);
      repeat (5) step();
      in_key = ~k; in_mode = ~m; in_v0 = ~a; in_v1 = ~b;
      wait_done(lat);
      chk("latched_inputs", {out_v0, out_v1}, tea_model(m, a, b, k, R));
      handshake();
    end

    // Reset at round 10.
    start_block(1'b0, 32'h12345678, 32'h9ABCDEF0, 128'h0123456789ABCDEF_FEDCBA9876543210);
    repeat (20) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midrst_outputs", {out_v0, out_v1}, 64'd0);
    chk("midrst_flags", {61'd0, out_valid, busy, in_ready}, {61'd0, 3'b001});
    seen = 1'b0;
    for (int i = 0; i < 2 * R + 10; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", {63'd0, seen}, 64'd0);
    a = $urandom(); b = $urandom(); k = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(1'b0, a, b, k);
    wait_done(lat);
    chk("post_rst_lat", 64'(lat), 64'(2 * R));
    chk("post_rst_block", {out_v0, out_v1}, tea_model(1'b0, a, b, k, R));
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tea_cipher_core.md
Name: tea_cipher_core

Overview:
Parametrised TEA block-cipher engine that encrypts or decrypts one 64-bit block under a 128-bit key per transaction.
- Full-width operands (no 10-bit truncation); per-transaction mode select; configurable round count.
- valid/ready handshakes on input and output.
- Sits between a host-side loader FSM (switch/UART/bus) and the display/result path, replacing the hard-wired 32-round encrypt-then-decrypt sequencer.

Parameters:
ROUNDS, 32, number of Feistel cycles per block; legal range 1..255.
DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
in_valid  in  1  request carries a valid block
in_ready  out  1  core can accept a block
in_mode  in  1  0 = encrypt, 1 = decrypt
in_v0  in  32  block word 0
in_v1  in  32  block word 1
in_key  in  128  key; k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0]
out_valid  out  1  result block valid
out_ready  in  1  consumer accepts result
out_v0  out  32  result word 0
out_v1  out  32  result word 1
busy  out  1  high in any state except IDLE

Behaviour:
- Reset is synchronous, active-low, on clk: resetn sampled low forces state to IDLE. It also clears v0, v1, sum, round counter, out_v0, out_v1, out_valid, and busy. in_ready is 1 in the cycle after reset releases. Reset mid-operation aborts the block and discards it; no partial output is produced.
- States: IDLE, HALF0, HALF1, DONE.
- in_ready = (state == IDLE). in_valid is ignored in every other state.
- IDLE: on in_valid && in_ready:
  - latch v0, v1, key, and mode;
  - set sum = DELTA for encrypt, or DELTA*ROUNDS mod 2^32 for decrypt (0xC6EF3720 at default);
  - round counter = 0; go to HALF0.
- F(x, ka, kb, s) = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb). Shifts are logical; all additions and subtractions are mod 2^32.
- Encrypt:
  - HALF0: v0 <= v0 + F(v1, k0, k1, sum).
  - HALF1: v1 <= v1 + F(v0_new, k2, k3, sum); sum <= sum + DELTA; counter++.
- Decrypt:
  - HALF0: v1 <= v1 - F(v0, k2, k3, sum).
  - HALF1: v0 <= v0 - F(v1_new, k0, k1, sum); sum <= sum - DELTA; counter++.
- HALF0 always goes to HALF1. HALF1 goes to DONE when counter == ROUNDS-1 (before increment); otherwise it returns to HALF0.
- Latency: out_valid rises exactly 2*ROUNDS rising edges after the accepting edge (64 at default). Throughput: one block per 2*ROUNDS+2 cycles with out_ready held high.
- On the edge entering DONE: out_v0/out_v1 <= final v0/v1, and out_valid <= 1.
- DONE:
  - out_v0, out_v1, and out_valid are held stable until out_valid && out_ready.
  - On that handshake, next state is IDLE and out_valid drops.
  - out_v0/out_v1 retain their last values until the next DONE entry or reset.
- A new block cannot be accepted in the DONE/IDLE handoff cycle: in_ready rises the cycle after the output handshake.
- Key and mode are latched at accept. Changes to in_key or in_mode during HALF*/DONE do not affect the block in flight.
- Round counter width is 8 bits, which covers the full ROUNDS range.
- Encrypt followed by decrypt under the same key and ROUNDS must return the original plaintext for any input.

Decomposition:
- Shared package tea_pkg:
  - TEA_DELTA constant;
  - state enum {IDLE, HALF0, HALF1, DONE};
  - mode constants MODE_ENC = 0, MODE_DEC = 1;
  - constant function for the initial decrypt sum (DELTA*ROUNDS truncated to 32 bits).
- One combinational sub-module, tea_mix: inputs x, ka, kb, s (32 bits each); output F (32 bits). It is instantiated once and its operand muxes are selected by state and mode.
- Sequencing and the register file stay in tea_cipher_core.

Test Plan:
- Default params; encrypt v0 = 0, v1 = 0, key = 0 -> out_v0 = 0x41EA3A0A, out_v1 = 0x94BAA940; out_valid exactly 64 edges after the accept edge.
- Decrypt 0x41EA3A0A / 0x94BAA940, key = 0 -> 0x00000000 / 0x00000000. Then 200 random blocks and keys, encrypt then decrypt -> plaintext is recovered every time.
- ROUNDS = 1; encrypt zeros with key = 0 -> out_v0 = 0x9E3779B9, out_v1 = 0xDBE8D32F; out_valid after 2 edges.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> outputs are stable and in_ready = 0. Assert out_ready -> IDLE next cycle; a pending in_valid is accepted one cycle later.
- Change in_key and in_mode mid-block -> result matches the values latched at accept.
- Assert resetn = 0 for one cycle at round 10 -> all outputs are zero, state is IDLE, no out_valid pulse. The next block completes correctly.
